fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Sequencer and arbiter for the framebuffer write port. Two pixel requesters with valid/ready handshakes share the single write port, granted round-robin. An optional built-in engine fills the whole 640x480 buffer with one colour. The outputs drive the framebuffer's `x`, `y`, `VGA_Cin` and `pixel_write` inputs directly, on the same `CLOCK_50` domain.

## Interface

**Parameters**
- `H_PIXELS`, default 640: visible width; valid x range is 0..H_PIXELS-1.
- `V_PIXELS`, default 480: visible height; valid y range is 0..V_PIXELS-1.
- `DROP_W`, default 16: width of the dropped-write counter.

**Ports**
- `CLOCK_50` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `req0_valid` in 1: requester 0 holds a pixel.
- `req0_x` in 11, `req0_y` in 11, `req0_color` in 8: requester 0 pixel.
- `req0_ready` out 1: requester 0 transfer accepted this cycle.
- `req1_valid`, `req1_x`, `req1_y`, `req1_color`, `req1_ready`: same as requester 0.
- `clear_start` in 1: one-cycle pulse that starts a full-screen clear.
- `clear_color` in 8: fill colour, sampled with `clear_start`.
- `clear_busy` out 1: clear in progress.
- `x` out 11, `y` out 11: write coordinates to the framebuffer.
- `VGA_Cin` out 8: write colour to the framebuffer.
- `pixel_write` out 1: write strobe to the framebuffer.
- `drop_count` out DROP_W: saturating count of out-of-range requests.

## Operation

**State machine**
- IDLE: serve requesters.
  - `clear_start`=1 goes to CLEAR.
- CLEAR: sweep the buffer.
  - After pixel (H_PIXELS-1, V_PIXELS-1) is issued, go to IDLE.
- Reset state is IDLE.

**Handshake and arbitration (IDLE only)**
- A transfer occurs when `reqN_valid` & `reqN_ready`.
- Valid must not depend on ready. A requester holds valid and data stable until the transfer.
- `reqN_ready` is combinational. It is 0 in CLEAR, and 0 in IDLE when `clear_start`=1.
- At most one ready per cycle.
- One requester valid: that requester gets ready.
- Both valid: grant the requester that is not `last_grant`.
- `last_grant` is a 1-bit register, reset to 1, so requester 0 wins the first tie. It updates only on a transfer.

**Range check**
- A transfer with x >= H_PIXELS or y >= V_PIXELS is accepted (ready as normal) but not written.
- On such a transfer: `pixel_write` stays 0, and `drop_count` increments, saturating at all-ones. `x`, `y` and `VGA_Cin` hold their previous values.

**Clear**
- On entry, latch `clear_color` and set counters cx=0, cy=0.
- Each CLEAR cycle issues a write of (cx, cy, latched colour), then advances the counters:
  - cx increments.
  - At cx=H_PIXELS-1, cx wraps to 0 and cy increments.
- `clear_start` is ignored while in CLEAR.
- Requests wait: valid stays asserted and ready stays 0.

**Outputs**
- `x`, `y`, `VGA_Cin` and `pixel_write` are registered.
- When no write is issued, `pixel_write`=0 and `x`, `y`, `VGA_Cin` hold their last values.

## Timing

**Reset**
- `x`=0, `y`=0, `VGA_Cin`=0, `pixel_write`=0, `clear_busy`=0, `drop_count`=0, state IDLE, `last_grant`=1.
- `reqN_ready`=0 while `reset` is high.
- Reset during CLEAR aborts the sweep immediately. No further clear writes occur.

**Request latency**
- A transfer at edge E produces `pixel_write`=1 with that data in the cycle after E, for exactly one cycle.
- Back-to-back transfers give one write per cycle, i.e. 100% port throughput.

**Clear timing**
- `clear_start` sampled at edge E0 raises `clear_busy` after E0.
- Clear writes appear in the H_PIXELS*V_PIXELS cycles after E1 .. E(H*V), in raster order.
- At E(H*V): state returns to IDLE and `clear_busy` falls. `pixel_write` for the last pixel is visible in that same cycle.
- `clear_busy` is high for exactly 307200 cycles at default parameters.
- The first requester transfer after a clear can occur in the cycle `clear_busy` is low.

**Simultaneous events**
- `clear_start` together with a valid request in IDLE: the clear wins and no transfer happens.

## Configuration

- `FB_CLEAR_EN` defined:
  - The clear engine and CLEAR state are compiled in, with behaviour as above.
- `FB_CLEAR_EN` undefined:
  - No CLEAR state, counters or colour latch.
  - `clear_start` and `clear_color` are ignored.
  - `clear_busy` is tied 0.
  - `reqN_ready` ignores `clear_start`.
  - Arbitration and range check are unchanged.

## Test plan

- **Reset:** assert `reset` mid-stream → all outputs 0 and both readys 0 while high. After release, a lone `req0_valid` with (4,0,127) → `pixel_write`=1, `x`=4, `y`=0, `VGA_Cin`=127 one cycle after the transfer.
- **Round-robin:** hold both valid for 4 cycles → grants 0,1,0,1, one `pixel_write` per cycle, each with the granted requester's data.
- **Out of range:** `req1` with (640,10,5), then (3,480,5) → both accepted, no `pixel_write`, `drop_count`=2. Force 65537 drops → `drop_count`=65535.
- **Clear (`FB_CLEAR_EN`):** pulse `clear_start`, `clear_color`=8'h20 → 307200 consecutive writes. First write is (0,0), the write after (639,0) is (0,1), last is (639,479), all colour 8'h20. `clear_busy` high for exactly 307200 cycles.
- **Clear contention:** `req0_valid` held through the clear → ready 0 throughout; transfer in the first cycle after `clear_busy` falls. A second `clear_start` mid-sweep has no effect. Reset at pixel 1000 → writes stop and `clear_busy`=0.
- **Without `FB_CLEAR_EN`:** pulse `clear_start` → `clear_busy` stays 0, no writes, and a concurrent request is accepted that cycle.

Source files
------------

// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write-port bundle: two requester handshakes, clear control and the framebuffer write outputs.
// master = pixel/clear sources, slave = the arbiter.
interface fb_write_arbiter_if #(
    parameter int DROP_W = 16
);
    logic              req0_valid;
    logic [10:0]       req0_x;
    logic [10:0]       req0_y;
    logic [7:0]        req0_color;
    logic              req0_ready;
    logic              req1_valid;
    logic [10:0]       req1_x;
    logic [10:0]       req1_y;
    logic [7:0]        req1_color;
    logic              req1_ready;
    logic              clear_start;
    logic [7:0]        clear_color;
    logic              clear_busy;
    logic [10:0]       x;
    logic [10:0]       y;
    logic [7:0]        VGA_Cin;
    logic              pixel_write;
    logic [DROP_W-1:0] drop_count;

    modport master (
        output req0_valid, req0_x, req0_y, req0_color,
        output req1_valid, req1_x, req1_y, req1_color,
        output clear_start, clear_color,
        input  req0_ready, req1_ready, clear_busy,
        input  x, y, VGA_Cin, pixel_write, drop_count
    );

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_color,
        input  req1_valid, req1_x, req1_y, req1_color,
        input  clear_start, clear_color,
        output req0_ready, req1_ready, clear_busy,
        output x, y, VGA_Cin, pixel_write, drop_count
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the framebuffer write port with range check and drop counter.
// Define FB_CLEAR_EN to compile in the full-screen clear engine.
module fb_write_arbiter #(
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480,
    parameter int DROP_W   = 16
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    fb_write_arbiter_if.slave   bus
);
    localparam logic [10:0] H_LIM  = 11'(H_PIXELS);
    localparam logic [10:0] V_LIM  = 11'(V_PIXELS);
    localparam logic [10:0] H_LAST = 11'(H_PIXELS - 1);
    localparam logic [10:0] V_LAST = 11'(V_PIXELS - 1);

    logic [10:0]       r_x;
    logic [10:0]       r_y;
    logic [7:0]        r_color;
    logic              r_pixel_write;
    logic [DROP_W-1:0] r_drop;
    logic              r_last_grant;

    logic              w_block;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_xfer;
    logic [10:0]       w_sel_x;
    logic [10:0]       w_sel_y;
    logic [7:0]        w_sel_color;
    logic              w_in_range;

`ifdef FB_CLEAR_EN
    typedef enum logic {S_IDLE, S_CLEAR} state_t;
    state_t      r_state;
    logic [10:0] r_cx;
    logic [10:0] r_cy;
    logic [7:0]  r_fill;

    // A pending clear_start outranks any requester in the same cycle.
    assign w_block         = reset | (r_state != S_IDLE) | bus.clear_start;
    assign bus.clear_busy  = (r_state == S_CLEAR);
`else
    logic w_unused_clear;
    assign w_unused_clear  = &{1'b0, bus.clear_start, bus.clear_color};
    assign w_block         = reset;
    assign bus.clear_busy  = 1'b0;
`endif

    // On a tie, the requester that did not win last time is granted.
    assign w_grant0    = !w_block && bus.req0_valid && (!bus.req1_valid || r_last_grant);
    assign w_grant1    = !w_block && bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    assign w_xfer      = w_grant0 | w_grant1;
    assign w_sel_x     = w_grant1 ? bus.req1_x     : bus.req0_x;
    assign w_sel_y     = w_grant1 ? bus.req1_y     : bus.req0_y;
    assign w_sel_color = w_grant1 ? bus.req1_color : bus.req0_color;
    assign w_in_range  = (w_sel_x < H_LIM) && (w_sel_y < V_LIM);

    assign bus.req0_ready  = w_grant0;
    assign bus.req1_ready  = w_grant1;
    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.VGA_Cin     = r_color;
    assign bus.pixel_write = r_pixel_write;
    assign bus.drop_count  = r_drop;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_color       <= '0;
            r_pixel_write <= 1'b0;
            r_drop        <= '0;
            r_last_grant  <= 1'b1;
`ifdef FB_CLEAR_EN
            r_state       <= S_IDLE;
            r_cx          <= '0;
            r_cy          <= '0;
            r_fill        <= '0;
`endif
        end else begin
            r_pixel_write <= 1'b0;
`ifdef FB_CLEAR_EN
            if (r_state == S_CLEAR) begin
                r_x           <= r_cx;
                r_y           <= r_cy;
                r_color       <= r_fill;
                r_pixel_write <= 1'b1;
                if (r_cx == H_LAST) begin
                    r_cx <= '0;
                    if (r_cy == V_LAST) begin
                        r_cy    <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cy <= r_cy + 11'd1;
                    end
                end else begin
                    r_cx <= r_cx + 11'd1;
                end
            end else if (bus.clear_start) begin
                r_state <= S_CLEAR;
                r_fill  <= bus.clear_color;
                r_cx    <= '0;
                r_cy    <= '0;
            end else
`endif
            if (w_xfer) begin
                r_last_grant <= w_grant1;
                if (w_in_range) begin
                    r_x           <= w_sel_x;
                    r_y           <= w_sel_y;
                    r_color       <= w_sel_color;
                    r_pixel_write <= 1'b1;
                end else if (r_drop != {DROP_W{1'b1}}) begin
                    r_drop <= r_drop + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: scenario tasks plus randomized traffic against a
// transaction-level model of the grant, range-check and drop-count rules.
module tb_fb_write_arbiter;
    localparam int H    = 64;
    localparam int V    = 48;
    localparam int DW   = 10;
    localparam int DMAX = (1 << DW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #10 clk = ~clk;

    fb_write_arbiter_if #(.DROP_W(DW)) bus();

    fb_write_arbiter #(.H_PIXELS(H), .V_PIXELS(V), .DROP_W(DW)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model state: last winner, visible write outputs, drop total.
    bit          m_last;
    bit          m_pw;
    logic [10:0] m_x, m_y;
    logic [7:0]  m_c;
    int          m_drops;
    logic        r0_obs, r1_obs;

    function automatic void model_reset();
        m_last = 1'b1; m_pw = 1'b0; m_x = '0; m_y = '0; m_c = '0; m_drops = 0;
    endfunction

    // -1: nobody granted, else requester index.
    function automatic int exp_grant(bit v0, bit v1, bit blocked);
        if (blocked || (!v0 && !v1)) return -1;
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        return m_last ? 0 : 1;
    endfunction

    function automatic void model_step(int g, logic [10:0] xx, logic [10:0] yy, logic [7:0] cc);
        m_pw = 1'b0;
        if (g >= 0) begin
            m_last = (g == 1);
            if (int'(xx) < H && int'(yy) < V) begin
                m_pw = 1'b1; m_x = xx; m_y = yy; m_c = cc;
            end else if (m_drops < DMAX) begin
                m_drops++;
            end
        end
    endfunction

    function automatic logic [10:0] rand_coord(int lim);
        if ($urandom_range(7, 0) == 0) return 11'($urandom_range(2047, lim));
        return 11'($urandom_range(lim - 1, 0));
    endfunction

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req0_x = '0; bus.req0_y = '0; bus.req0_color = '0;
        bus.req1_valid = 0; bus.req1_x = '0; bus.req1_y = '0; bus.req1_color = '0;
        bus.clear_start = 0; bus.clear_color = '0;
    endtask

    // Inputs are set at posedge+1; readys sampled mid-cycle, outputs at the next posedge+1.
    task automatic tick();
        #5;
        r0_obs = bus.req0_ready;
        r1_obs = bus.req1_ready;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        #25;
        reset = 1'b0;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.req0_valid = 1; bus.req0_x = 11'(10 + i); bus.req0_y = 11'(10); bus.req0_color = 8'(i + 1);
            tick();
        end
        bus.req1_valid = 1;
        reset = 1'b1;
        #5;
        checks++;
        if ({r0_obs, r1_obs, bus.req0_ready, bus.req1_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ready: got r0=%b r1=%b, required 0 0", bus.req0_ready, bus.req1_ready);
        end
        checks++;
        if ({bus.pixel_write, bus.x, bus.y, bus.VGA_Cin, bus.drop_count, bus.clear_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got pw=%b x=%0d y=%0d c=%0d drop=%0d busy=%b, required all 0",
                     bus.pixel_write, bus.x, bus.y, bus.VGA_Cin, bus.drop_count, bus.clear_busy);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.pixel_write, bus.x} !== 12'd0) begin
            errors++;
            $display("FAIL reset_hold: got pw=%b x=%0d while reset high, required 0 0", bus.pixel_write, bus.x);
        end
        idle_inputs();
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        bus.req0_valid = 1; bus.req0_x = 11'd4; bus.req0_y = 11'd0; bus.req0_color = 8'd127;
        tick();
        checks++;
        if ({r0_obs, r1_obs} !== 2'b10) begin
            errors++;
            $display("FAIL first_ready: got r0=%b r1=%b, required 1 0", r0_obs, r1_obs);
        end
        checks++;
        if ({bus.pixel_write, bus.x, bus.y, bus.VGA_Cin} !== {1'b1, 11'd4, 11'd0, 8'd127}) begin
            errors++;
            $display("FAIL first_write: got pw=%b (%0d,%0d,%0d), required 1 (4,0,127)",
                     bus.pixel_write, bus.x, bus.y, bus.VGA_Cin);
        end
        $display("xfer req0 x=4 y=0 c=127 write");
        bus.req0_valid = 0;
        tick();
        checks++;
        if ({bus.pixel_write, bus.x} !== {1'b0, 11'd4}) begin
            errors++;
            $display("FAIL single_pulse: got pw=%b x=%0d, required 0 4", bus.pixel_write, bus.x);
        end
    endtask

    task automatic test_round_robin();
        int          seq [4];
        int          want [4] = '{0, 1, 0, 1};
        logic [10:0] dx [2], dy [2];
        logic [7:0]  dc [2];
        int          g;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            dx[r] = rand_coord(H) % 11'(H); dy[r] = 11'($urandom_range(V - 1, 0)); dc[r] = 8'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            bus.req0_valid = 1; bus.req0_x = dx[0]; bus.req0_y = dy[0]; bus.req0_color = dc[0];
            bus.req1_valid = 1; bus.req1_x = dx[1]; bus.req1_y = dy[1]; bus.req1_color = dc[1];
            g = exp_grant(1, 1, 0);
            tick();
            seq[i] = r1_obs ? 1 : (r0_obs ? 0 : -1);
            model_step(g, dx[g], dy[g], dc[g]);
            checks++;
            if ({bus.pixel_write, bus.x, bus.y, bus.VGA_Cin} !== {m_pw, m_x, m_y, m_c}) begin
                errors++;
                $display("FAIL rr_write%0d: got pw=%b (%0d,%0d,%0d), required %b (%0d,%0d,%0d)", i,
                         bus.pixel_write, bus.x, bus.y, bus.VGA_Cin, m_pw, m_x, m_y, m_c);
            end
            $display("xfer req%0d x=%0d y=%0d c=%0d write", seq[i], bus.x, bus.y, bus.VGA_Cin);
            dx[g] = 11'($urandom_range(H - 1, 0)); dy[g] = 11'($urandom_range(V - 1, 0)); dc[g] = 8'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seq[i] !== want[i]) begin
                errors++;
                $display("FAIL rr_grant%0d: got req%0d, required req%0d", i, seq[i], want[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_out_of_range();
        int pw_seen = 0;
        do_reset();
        bus.req1_valid = 1; bus.req1_x = 11'(H); bus.req1_y = 11'd10; bus.req1_color = 8'd5;
        tick();
        checks++;
        if ({r1_obs, bus.pixel_write} !== 2'b10) begin
            errors++;
            $display("FAIL oor_x: got ready=%b pw=%b, required 1 0", r1_obs, bus.pixel_write);
        end
        $display("xfer req1 x=%0d y=10 c=5 drop", H);
        bus.req1_x = 11'd3; bus.req1_y = 11'(V);
        tick();
        checks++;
        if ({r1_obs, bus.pixel_write, bus.x, bus.y, bus.VGA_Cin} !== {2'b10, 11'd0, 11'd0, 8'd0}) begin
            errors++;
            $display("FAIL oor_y: got ready=%b pw=%b (%0d,%0d,%0d), required 1 0 (0,0,0)",
                     r1_obs, bus.pixel_write, bus.x, bus.y, bus.VGA_Cin);
        end
        $display("xfer req1 x=3 y=%0d c=5 drop", V);
        checks++;
        if (bus.drop_count !== DW'(2)) begin
            errors++;
            $display("FAIL drop_two: got %0d, required 2", bus.drop_count);
        end
        bus.req1_valid = 0;
        bus.req0_valid = 1; bus.req0_x = 11'd2047; bus.req0_y = 11'd0;
        for (int i = 0; i < DMAX + 2; i++) begin
            tick();
            if (bus.pixel_write) pw_seen++;
        end
        checks++;
        if (bus.drop_count !== DW'(DMAX) || pw_seen != 0) begin
            errors++;
            $display("FAIL drop_saturate: got count=%0d writes=%0d, required %0d 0", bus.drop_count, pw_seen, DMAX);
        end
        idle_inputs();
        m_drops = DMAX;
        m_last = 1'b0;
    endtask

    task automatic test_random(int n);
        bit          pv [2];
        logic [10:0] px [2], py [2];
        logic [7:0]  pc [2];
        logic [DW-1:0] exp_d;
        int          g;
        int          bad = 0;
        pv[0] = 0; pv[1] = 0;
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && $urandom_range(9, 0) < 6) begin
                    pv[r] = 1; px[r] = rand_coord(H); py[r] = rand_coord(V); pc[r] = 8'($urandom);
                end
            end
            bus.req0_valid = pv[0]; bus.req0_x = px[0]; bus.req0_y = py[0]; bus.req0_color = pc[0];
            bus.req1_valid = pv[1]; bus.req1_x = px[1]; bus.req1_y = py[1]; bus.req1_color = pc[1];
            g = exp_grant(pv[0], pv[1], 0);
            tick();
            checks++;
            if ({r1_obs, r0_obs} !== ((g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00)) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL rand_ready: cycle %0d got r0=%b r1=%b, required grant %0d", i, r0_obs, r1_obs, g);
            end
            if (g >= 0) begin
                model_step(g, px[g], py[g], pc[g]);
                pv[g] = 0;
                $display("xfer req%0d x=%0d y=%0d c=%0d %s", g, px[g], py[g], pc[g], m_pw ? "write" : "drop");
            end else begin
                model_step(-1, '0, '0, '0);
            end
            exp_d = DW'(m_drops);
            checks++;
            if ({bus.pixel_write, bus.x, bus.y, bus.VGA_Cin, bus.drop_count} !== {m_pw, m_x, m_y, m_c, exp_d}) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL rand_out: cycle %0d got pw=%b (%0d,%0d,%0d) drop=%0d, required %b (%0d,%0d,%0d) drop=%0d",
                                      i, bus.pixel_write, bus.x, bus.y, bus.VGA_Cin, bus.drop_count,
                                      m_pw, m_x, m_y, m_c, m_drops);
            end
        end
        idle_inputs();
    endtask

`ifdef FB_CLEAR_EN
    task automatic test_clear();
        int bad_px = 0, bad_rdy = 0, busy_cycles = 0;
        do_reset();
        bus.req0_valid = 1; bus.req0_x = 11'd7; bus.req0_y = 11'd8; bus.req0_color = 8'd9;
        bus.clear_start = 1; bus.clear_color = 8'h20;
        tick();
        checks++;
        if ({r0_obs, bus.pixel_write, bus.clear_busy} !== 3'b001) begin
            errors++;
            $display("FAIL clear_start: got ready=%b pw=%b busy=%b, required 0 0 1", r0_obs, bus.pixel_write, bus.clear_busy);
        end
        bus.clear_start = 0; bus.clear_color = 8'h00;
        if (bus.clear_busy) busy_cycles++;
        for (int k = 0; k < H * V; k++) begin
            bus.clear_start = (k == 100);
            bus.clear_color = (k == 100) ? 8'h55 : 8'h00;
            tick();
            if (r0_obs || r1_obs) bad_rdy++;
            if ({bus.pixel_write, bus.x, bus.y, bus.VGA_Cin} !== {1'b1, 11'(k % H), 11'(k / H), 8'h20}) begin
                bad_px++;
                if (bad_px < 4) $display("FAIL clear_px%0d: got pw=%b (%0d,%0d,%0h), required 1 (%0d,%0d,20)",
                                         k, bus.pixel_write, bus.x, bus.y, bus.VGA_Cin, k % H, k / H);
            end
            if (k == H) begin
                checks++;
                if ({bus.x, bus.y} !== {11'd0, 11'd1}) begin
                    errors++;
                    $display("FAIL clear_wrap: got (%0d,%0d), required (0,1)", bus.x, bus.y);
                end
            end
            if (bus.clear_busy) busy_cycles++;
        end
        checks++;
        if (bad_px != 0) begin
            errors++;
            $display("FAIL clear_sweep: got %0d bad pixels, required 0", bad_px);
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL clear_ready: got %0d ready cycles during clear, required 0", bad_rdy);
        end
        checks++;
        if ({bus.x, bus.y, bus.clear_busy} !== {11'(H - 1), 11'(V - 1), 1'b0}) begin
            errors++;
            $display("FAIL clear_last: got (%0d,%0d) busy=%b, required (%0d,%0d) 0", bus.x, bus.y, bus.clear_busy, H - 1, V - 1);
        end
        checks++;
        if (busy_cycles != H * V) begin
            errors++;
            $display("FAIL clear_busy_len: got %0d, required %0d", busy_cycles, H * V);
        end
        $display("clear done: %0d writes colour 20", H * V);
        m_x = 11'(H - 1); m_y = 11'(V - 1); m_c = 8'h20;
        tick();
        model_step(exp_grant(1, 0, 0), 11'd7, 11'd8, 8'd9);
        checks++;
        if ({r0_obs, bus.pixel_write, bus.x, bus.y, bus.VGA_Cin} !== {1'b1, m_pw, m_x, m_y, m_c}) begin
            errors++;
            $display("FAIL post_clear_xfer: got ready=%b pw=%b (%0d,%0d,%0d), required 1 1 (7,8,9)",
                     r0_obs, bus.pixel_write, bus.x, bus.y, bus.VGA_Cin);
        end
        $display("xfer req0 x=7 y=8 c=9 write");
        idle_inputs();
    endtask

    task automatic test_clear_reset();
        int pw_after = 0, busy_after = 0;
        do_reset();
        bus.clear_start = 1; bus.clear_color = 8'h03;
        tick();
        idle_inputs();
        for (int k = 0; k < 1000; k++) tick();
        reset = 1'b1;
        #5;
        checks++;
        if ({bus.clear_busy, bus.pixel_write} !== 2'b00) begin
            errors++;
            $display("FAIL clear_abort: got busy=%b pw=%b, required 0 0", bus.clear_busy, bus.pixel_write);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.pixel_write) pw_after++;
            if (bus.clear_busy) busy_after++;
        end
        checks++;
        if (pw_after != 0 || busy_after != 0) begin
            errors++;
            $display("FAIL clear_abort_after: got writes=%0d busy=%0d, required 0 0", pw_after, busy_after);
        end
    endtask
`else
    task automatic test_no_clear();
        int pw_after = 0, busy_after = 0;
        do_reset();
        bus.clear_start = 1; bus.clear_color = 8'hff;
        bus.req0_valid = 1; bus.req0_x = 11'd1; bus.req0_y = 11'd2; bus.req0_color = 8'd3;
        tick();
        checks++;
        if ({r0_obs, bus.clear_busy, bus.pixel_write, bus.x, bus.y, bus.VGA_Cin} !== {3'b101, 11'd1, 11'd2, 8'd3}) begin
            errors++;
            $display("FAIL no_clear_xfer: got ready=%b busy=%b pw=%b (%0d,%0d,%0d), required 1 0 1 (1,2,3)",
                     r0_obs, bus.clear_busy, bus.pixel_write, bus.x, bus.y, bus.VGA_Cin);
        end
        $display("xfer req0 x=1 y=2 c=3 write");
        idle_inputs();
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.pixel_write) pw_after++;
            if (bus.clear_busy) busy_after++;
        end
        checks++;
        if (pw_after != 0 || busy_after != 0) begin
            errors++;
            $display("FAIL no_clear_idle: got writes=%0d busy=%0d, required 0 0", pw_after, busy_after);
        end
        m_last = 1'b0; m_pw = 1'b0; m_x = 11'd1; m_y = 11'd2; m_c = 8'd3;
    endtask
`endif

    initial begin
        model_reset();
        idle_inputs();
        test_reset();
        test_round_robin();
        test_out_of_range();
        test_random(400);
`ifdef FB_CLEAR_EN
        test_clear();
        test_random(100);
        test_clear_reset();
`else
        test_no_clear();
        test_random(100);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
